// File: rtl/bitwise_unit_mc.sv
// Multicycle AND/OR/XOR/NOR unit, one SLICE-bit slice per clock,
// with valid/ready handshakes on the operand and result sides.
module bitwise_unit_mc #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] value1,
    input  logic [WIDTH-1:0] value2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = $clog2(NSLICE + 1);
    localparam logic [WIDTH-1:0] MASK = WIDTH'({SLICE{1'b1}});

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [CW-1:0]     cnt;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [1:0]        op_q;
    logic [WIDTH-1:0]  result_q;
    logic [31:0]       sh;
    logic [WIDTH-1:0]  a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic [SLICE-1:0]  a_s;
    logic [SLICE-1:0]  b_s;
    logic [SLICE-1:0]  r_s;
    logic              last;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign result    = result_q;
    assign zero      = ~|result_q;

    assign last = (cnt == CW'(NSLICE - 1));
    assign sh   = 32'(cnt) * 32'(SLICE);
    assign a_sh = a_q >> sh;
    assign b_sh = b_q >> sh;
    assign a_s  = a_sh[SLICE-1:0];
    assign b_s  = b_sh[SLICE-1:0];

    always_comb begin
        r_s = '0;
        unique case (op_q)
            2'b00: r_s = a_s & b_s;
            2'b01: r_s = a_s | b_s;
            2'b10: r_s = a_s ^ b_s;
            2'b11: r_s = ~(a_s | b_s);
            default: r_s = '0;
        endcase
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (in_valid) state_nx = RUN;
            RUN:  if (last) state_nx = DONE;
            DONE: if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Counter parks at the last slice so it never wraps.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q  <= value1;
                        b_q  <= value2;
                        op_q <= op;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    result_q <= (result_q & ~(MASK << sh))
                              | (WIDTH'(r_s) << sh);
                    if (!last) cnt <= cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bitwise_unit_mc.sv
// Directed bench for bitwise_unit_mc: default 32/8 plus the
// 32/32 and 64/16 configurations side by side.
module tb_bitwise_unit_mc;

    logic        clk;
    logic        rst;
    logic [2:0]  in_valid;
    logic [2:0]  out_ready;
    logic [1:0]  op_s [3];
    logic [63:0] va   [3];
    logic [63:0] vb   [3];
    wire  [2:0]  in_ready;
    wire  [2:0]  out_valid;
    wire  [2:0]  zero;
    wire  [31:0] r0;
    wire  [31:0] r1;
    wire  [63:0] r2;
    logic [63:0] res  [3];

    int vecs;
    int errs;

    assign res[0] = {32'b0, r0};
    assign res[1] = {32'b0, r1};
    assign res[2] = r2;

    bitwise_unit_mc #(.WIDTH(32), .SLICE(8)) d0 (
        .clock(clk), .reset(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .op(op_s[0]), .value1(va[0][31:0]), .value2(vb[0][31:0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .result(r0), .zero(zero[0])
    );

    bitwise_unit_mc #(.WIDTH(32), .SLICE(32)) d1 (
        .clock(clk), .reset(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .op(op_s[1]), .value1(va[1][31:0]), .value2(vb[1][31:0]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .result(r1), .zero(zero[1])
    );

    bitwise_unit_mc #(.WIDTH(64), .SLICE(16)) d2 (
        .clock(clk), .reset(rst),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .op(op_s[2]), .value1(va[2]), .value2(vb[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .result(r2), .zero(zero[2])
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] ref_op(input logic [1:0] o,
                                           input logic [63:0] a,
                                           input logic [63:0] b,
                                           input int w);
        logic [63:0] r;
        logic [63:0] m;
        case (o)
            2'b00:   r = a & b;
            2'b01:   r = a | b;
            2'b10:   r = a ^ b;
            default: r = ~(a | b);
        endcase
        m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        return r & m;
    endfunction

    task automatic issue(input int s, input logic [1:0] o,
                         input logic [63:0] a, input logic [63:0] b,
                         output int lat);
        int n;
        n = 0;
        while (!in_ready[s] && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        op_s[s] = o;
        va[s] = a;
        vb[s] = b;
        in_valid[s] = 1'b1;
        @(posedge clk); #1;
        in_valid[s] = 1'b0;
        lat = 0;
        while (!out_valid[s] && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_out(input int s);
        out_ready[s] = 1'b1;
        @(posedge clk); #1;
        out_ready[s] = 1'b0;
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            vecs++;
            if (in_ready[s] !== 1'b1 || out_valid[s] !== 1'b0 ||
                res[s] !== 64'h0 || zero[s] !== 1'b1) begin
                errs++;
                $display("FAIL reset dut%0d: rdy=%b vld=%b res=%h z=%b want 1 0 0 1",
                         s, in_ready[s], out_valid[s], res[s], zero[s]);
            end
        end
    endtask

    task automatic test_xor();
        int lat;
        issue(0, 2'b10, 64'hFFFF0000, 64'h0F0F0F0F, lat);
        vecs++;
        if (lat !== 4) begin
            errs++;
            $display("FAIL xor_latency: got %0d want 4", lat);
        end
        vecs++;
        if (res[0] !== 64'hF0F00F0F || zero[0] !== 1'b0) begin
            errs++;
            $display("FAIL xor_result: got %h z=%b want f0f00f0f z=0",
                     res[0], zero[0]);
        end
        release_out(0);
        vecs++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
            errs++;
            $display("FAIL xor_handshake: rdy=%b vld=%b want 1 0",
                     in_ready[0], out_valid[0]);
        end
    endtask

    task automatic test_and_nor();
        int lat;
        issue(0, 2'b00, 64'h12345678, 64'h0000FFFF, lat);
        vecs++;
        if (lat !== 4 || res[0] !== 64'h00005678) begin
            errs++;
            $display("FAIL and: got %h lat %0d want 00005678 lat 4",
                     res[0], lat);
        end
        release_out(0);
        issue(0, 2'b11, 64'h0, 64'h0, lat);
        vecs++;
        if (res[0] !== 64'hFFFFFFFF || zero[0] !== 1'b0) begin
            errs++;
            $display("FAIL nor: got %h z=%b want ffffffff z=0",
                     res[0], zero[0]);
        end
        release_out(0);
    endtask

    task automatic test_zero();
        int lat;
        issue(0, 2'b10, 64'hA5A5A5A5, 64'hA5A5A5A5, lat);
        vecs++;
        if (res[0] !== 64'h0 || zero[0] !== 1'b1) begin
            errs++;
            $display("FAIL zero_flag: got %h z=%b want 0 z=1",
                     res[0], zero[0]);
        end
        release_out(0);
    endtask

    task automatic test_backpressure();
        int n;
        logic bad;
        op_s[0] = 2'b01;
        va[0] = 64'h0000FFFF;
        vb[0] = 64'hFF000000;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        vecs++;
        if (in_ready[0] !== 1'b0) begin
            errs++;
            $display("FAIL bp_accept: rdy=%b want 0", in_ready[0]);
        end
        op_s[0] = 2'b00;
        va[0] = 64'h0;
        vb[0] = 64'h0;
        n = 0;
        while (!out_valid[0] && n < 30) begin
            @(posedge clk); #1;
            in_valid[0] = ~in_valid[0];
            n++;
        end
        vecs++;
        if (res[0] !== 64'hFF00FFFF || n !== 4) begin
            errs++;
            $display("FAIL bp_isolation: got %h lat %0d want ff00ffff lat 4",
                     res[0], n);
        end
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid[0] = i[0];
            @(posedge clk); #1;
            if (out_valid[0] !== 1'b1 || res[0] !== 64'hFF00FFFF) bad = 1'b1;
        end
        vecs++;
        if (bad) begin
            errs++;
            $display("FAIL bp_hold: vld=%b res=%h want 1 ff00ffff",
                     out_valid[0], res[0]);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        op_s[0] = 2'b10;
        va[0] = 64'hFFFFFFFF;
        vb[0] = 64'h0000000F;
        in_valid[0] = 1'b1;
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        vecs++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
            errs++;
            $display("FAIL b2b_idle: rdy=%b vld=%b want 1 0",
                     in_ready[0], out_valid[0]);
        end
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        vecs++;
        if (in_ready[0] !== 1'b0) begin
            errs++;
            $display("FAIL b2b_accept: rdy=%b want 0", in_ready[0]);
        end
        n = 0;
        while (!out_valid[0] && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        vecs++;
        if (n !== 4 || res[0] !== 64'hFFFFFFF0) begin
            errs++;
            $display("FAIL b2b_result: got %h lat %0d want fffffff0 lat 4",
                     res[0], n);
        end
        release_out(0);
    endtask

    task automatic test_reset_mid_run();
        int lat;
        op_s[0] = 2'b01;
        va[0] = 64'hFFFFFFFF;
        vb[0] = 64'h0;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        vecs++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 ||
            res[0] !== 64'h0 || zero[0] !== 1'b1) begin
            errs++;
            $display("FAIL reset_mid_run: rdy=%b vld=%b res=%h z=%b want 1 0 0 1",
                     in_ready[0], out_valid[0], res[0], zero[0]);
        end
        #2;
        rst = 1'b0;
        issue(0, 2'b10, 64'h12345678, 64'hFFFFFFFF, lat);
        vecs++;
        if (lat !== 4 || res[0] !== 64'hEDCBA987) begin
            errs++;
            $display("FAIL post_reset_xor: got %h lat %0d want edcba987 lat 4",
                     res[0], lat);
        end
        release_out(0);
    endtask

    task automatic test_sweep();
        int lat;
        logic [63:0] e;
        logic [63:0] a1;
        logic [63:0] b1;
        logic [63:0] a2;
        logic [63:0] b2;
        a1 = 64'hDEADBEEF;
        b1 = 64'h0F0F00FF;
        a2 = 64'h0123456789ABCDEF;
        b2 = 64'hFFFF0000AAAA5555;
        for (int o = 0; o < 4; o++) begin
            issue(1, 2'(o), a1, b1, lat);
            e = ref_op(2'(o), a1, b1, 32);
            vecs++;
            if (lat !== 1 || res[1] !== e || zero[1] !== (e == 64'h0)) begin
                errs++;
                $display("FAIL sweep32x32 op%0d: got %h lat %0d want %h lat 1",
                         o, res[1], lat, e);
            end
            release_out(1);
            issue(2, 2'(o), a2, b2, lat);
            e = ref_op(2'(o), a2, b2, 64);
            vecs++;
            if (lat !== 4 || res[2] !== e || zero[2] !== (e == 64'h0)) begin
                errs++;
                $display("FAIL sweep64x16 op%0d: got %h lat %0d want %h lat 4",
                         o, res[2], lat, e);
            end
            release_out(2);
        end
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        rst = 1'b1;
        in_valid = '0;
        out_ready = '0;
        for (int s = 0; s < 3; s++) begin
            op_s[s] = 2'b00;
            va[s] = 64'h0;
            vb[s] = 64'h0;
        end
        #12;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_xor();
        test_and_nor();
        test_zero();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_run();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
